// File: rtl/mips_avalon_lsu.sv
// Load/store unit bridging the MIPS datapath to an Avalon-MM data bus: one outstanding
// byte/half/word access, registered bus outputs, lane extraction and sign/zero extension.
module mips_avalon_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic [3:0]  avm_byteenable,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t      state_q, state_d;
    logic [1:0]  size_q, size_d;
    logic        sign_q, sign_d;
    logic [1:0]  lane_q, lane_d;
    logic [31:0] tmo_q, tmo_d;
    logic        rd_q, rd_d, wr_q, wr_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        rvalid_q, rvalid_d, rerr_q, rerr_d;
    logic [31:0] rdata_q, rdata_d;

    logic        misalign;
    logic [3:0]  req_be;
    logic [31:0] req_wd;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] rd_ext;

    always_comb begin
        misalign = (req_size == 2'b11) ||
                   (req_size == 2'b01 && req_addr[0]) ||
                   (req_size == 2'b10 && req_addr[1:0] != 2'b00);
        case (req_size)
            2'b00: begin
                req_be = 4'b0001 << req_addr[1:0];
                req_wd = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                req_be = req_addr[1] ? 4'b1100 : 4'b0011;
                req_wd = {2{req_wdata[15:0]}};
            end
            default: begin
                req_be = 4'b1111;
                req_wd = req_wdata;
            end
        endcase
    end

    // Lane select and extension of the word seen on the completing edge
    always_comb begin
        case (lane_q)
            2'd0:    rd_byte = avm_readdata[7:0];
            2'd1:    rd_byte = avm_readdata[15:8];
            2'd2:    rd_byte = avm_readdata[23:16];
            default: rd_byte = avm_readdata[31:24];
        endcase
        rd_half = lane_q[1] ? avm_readdata[31:16] : avm_readdata[15:0];
        case (size_q)
            2'b00:   rd_ext = sign_q ? {{24{rd_byte[7]}}, rd_byte} : {24'h0, rd_byte};
            2'b01:   rd_ext = sign_q ? {{16{rd_half[15]}}, rd_half} : {16'h0, rd_half};
            default: rd_ext = avm_readdata;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        size_d   = size_q;
        sign_d   = sign_q;
        lane_d   = lane_q;
        tmo_d    = tmo_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        rvalid_d = 1'b0;
        rerr_d   = 1'b0;
        rdata_d  = rdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    size_d = req_size;
                    sign_d = req_signed;
                    lane_d = req_addr[1:0];
                    if (misalign) begin
                        state_d  = DONE;
                        rvalid_d = 1'b1;
                        rerr_d   = 1'b1;
                        rdata_d  = '0;
                    end else begin
                        addr_d  = {req_addr[31:2], 2'b00};
                        be_d    = req_be;
                        wdata_d = req_wd;
                        tmo_d   = '0;
                        if (req_write) begin
                            wr_d    = 1'b1;
                            state_d = WRITE;
                        end else begin
                            rd_d    = 1'b1;
                            state_d = READ;
                        end
                    end
                end
            end
            READ, WRITE: begin
                if (!avm_waitrequest) begin
                    rd_d     = 1'b0;
                    wr_d     = 1'b0;
                    state_d  = DONE;
                    rvalid_d = 1'b1;
                    rdata_d  = (state_q == READ) ? rd_ext : '0;
                end else if (TIMEOUT_CYCLES != 0) begin
                    if (tmo_q == TIMEOUT_CYCLES - 1) begin
                        rd_d     = 1'b0;
                        wr_d     = 1'b0;
                        state_d  = DONE;
                        rvalid_d = 1'b1;
                        rerr_d   = 1'b1;
                        rdata_d  = '0;
                    end else begin
                        tmo_d = tmo_q + 32'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            size_q   <= '0;
            sign_q   <= 1'b0;
            lane_q   <= '0;
            tmo_q    <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            rvalid_q <= 1'b0;
            rerr_q   <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            size_q   <= size_d;
            sign_q   <= sign_d;
            lane_q   <= lane_d;
            tmo_q    <= tmo_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            rvalid_q <= rvalid_d;
            rerr_q   <= rerr_d;
            rdata_q  <= rdata_d;
        end
    end

    assign req_ready      = (state_q == IDLE) & reset_n;
    assign resp_valid     = rvalid_q;
    assign resp_err       = rerr_q;
    assign resp_rdata     = rdata_q;
    assign avm_address    = addr_q;
    assign avm_read       = rd_q;
    assign avm_write      = wr_q;
    assign avm_writedata  = wdata_q;
    assign avm_byteenable = be_q;

endmodule

// File: tb/tb_mips_avalon_lsu.sv
// Directed bench for mips_avalon_lsu: a small Avalon slave with programmable wait states
// backs word/byte/half stores and loads, misalignment, timeout and mid-transfer reset.
module tb_mips_avalon_lsu;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata, avm_address, avm_writedata;
    logic        avm_read, avm_write, avm_waitrequest;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_readdata = '0;

    int tests = 0;
    int fails = 0;

    int  wait_cfg = 0;
    logic stuck = 1'b0;
    int  wcnt = 0;
    logic both_seen = 1'b0;
    logic [31:0] mem [logic [31:0]];

    mips_avalon_lsu #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
        .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .avm_address(avm_address), .avm_read(avm_read),
        .avm_write(avm_write), .avm_writedata(avm_writedata),
        .avm_byteenable(avm_byteenable), .avm_waitrequest(avm_waitrequest),
        .avm_readdata(avm_readdata)
    );

    always #5 clk = ~clk;

    assign avm_waitrequest = (avm_read | avm_write) & (stuck | (wcnt < wait_cfg));

    always @(posedge clk) begin
        if (!(avm_read | avm_write)) wcnt <= 0;
        else if (avm_waitrequest) wcnt <= wcnt + 1;
    end

    always @(posedge clk) begin
        logic [31:0] w;
        if (avm_write && !avm_waitrequest) begin
            w = mem.exists(avm_address) ? mem[avm_address] : 32'h0;
            for (int b = 0; b < 4; b++)
                if (avm_byteenable[b]) w[8*b +: 8] = avm_writedata[8*b +: 8];
            mem[avm_address] = w;
        end
    end

    always @(negedge clk) begin
        avm_readdata = mem.exists(avm_address) ? mem[avm_address] : 32'h0;
        if (avm_read && avm_write) both_seen = 1'b1;
    end

    // Issues one request and follows it to its response, reporting what the bus saw.
    task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] d,
                          output int strobes, output int lat, output logic [31:0] rd,
                          output logic er, output logic [31:0] adr, output logic [3:0] be,
                          output logic [31:0] wd, output logic got, output logic rv_after);
        @(negedge clk);
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
        req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = d;
        @(negedge clk);
        req_valid = 1'b0;
        strobes = 0; lat = 0; got = 1'b0; rd = 'x; er = 1'bx;
        adr = '0; be = '0; wd = '0; rv_after = 1'bx;
        for (int i = 1; i <= 40 && !got; i++) begin
            if (avm_read | avm_write) begin
                if (strobes == 0) begin adr = avm_address; be = avm_byteenable; wd = avm_writedata; end
                strobes++;
            end
            if (resp_valid) begin
                got = 1'b1; lat = i; rd = resp_rdata; er = resp_err;
            end else begin
                @(negedge clk);
            end
        end
        @(negedge clk);
        rv_after = resp_valid;
    endtask

    task automatic test_reset();
        @(negedge clk);
        tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL rst_ready got %b exp 0", req_ready); end
        tests++; if ({avm_read, avm_write, resp_valid, resp_err} !== 4'b0) begin fails++; $display("FAIL rst_strobes got %b exp 0000", {avm_read, avm_write, resp_valid, resp_err}); end
        tests++; if ({avm_address, avm_writedata, resp_rdata} !== 96'h0) begin fails++; $display("FAIL rst_data got %h exp 0", {avm_address, avm_writedata, resp_rdata}); end
        tests++; if (avm_byteenable !== 4'b0000) begin fails++; $display("FAIL rst_be got %b exp 0000", avm_byteenable); end
        reset_n = 1'b1;
        @(negedge clk);
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL rst_release_ready got %b exp 1", req_ready); end
    endtask

    task automatic test_word();
        int s, l; logic [31:0] rd, adr, wd; logic er, got, rv2; logic [3:0] be;
        wait_cfg = 2;
        do_req(1'b1, 2'b10, 1'b0, 32'h8000_0010, 32'hDEAD_BEEF, s, l, rd, er, adr, be, wd, got, rv2);
        tests++; if (got !== 1'b1) begin fails++; $display("FAIL sw_resp got %b exp 1", got); end
        tests++; if (s !== 3) begin fails++; $display("FAIL sw_strobe_cycles got %0d exp 3", s); end
        tests++; if (be !== 4'b1111) begin fails++; $display("FAIL sw_be got %b exp 1111", be); end
        tests++; if (adr !== 32'h8000_0010) begin fails++; $display("FAIL sw_addr got %h exp 80000010", adr); end
        tests++; if (wd !== 32'hDEAD_BEEF) begin fails++; $display("FAIL sw_wdata got %h exp deadbeef", wd); end
        tests++; if ({er, rd} !== {1'b0, 32'h0}) begin fails++; $display("FAIL sw_rsp got %b/%h exp 0/0", er, rd); end
        tests++; if (rv2 !== 1'b0) begin fails++; $display("FAIL sw_resp_pulse got %b exp 0", rv2); end
        do_req(1'b0, 2'b10, 1'b0, 32'h8000_0010, 32'h0, s, l, rd, er, adr, be, wd, got, rv2);
        tests++; if (rd !== 32'hDEAD_BEEF) begin fails++; $display("FAIL lw_rdata got %h exp deadbeef", rd); end
        tests++; if (s !== 3 || l !== 4) begin fails++; $display("FAIL lw_timing got %0d/%0d exp 3/4", s, l); end
        wait_cfg = 0;
    endtask

    task automatic test_byte();
        int s, l; logic [31:0] rd, adr, wd; logic er, got, rv2; logic [3:0] be;
        do_req(1'b1, 2'b00, 1'b0, 32'h0000_0003, 32'h0000_00A5, s, l, rd, er, adr, be, wd, got, rv2);
        tests++; if (wd !== 32'hA5A5_A5A5) begin fails++; $display("FAIL sb_wdata got %h exp a5a5a5a5", wd); end
        tests++; if (be !== 4'b1000) begin fails++; $display("FAIL sb_be got %b exp 1000", be); end
        tests++; if (adr !== 32'h0) begin fails++; $display("FAIL sb_addr got %h exp 0", adr); end
        tests++; if (s !== 1 || l !== 2) begin fails++; $display("FAIL sb_latency got %0d/%0d exp 1/2", s, l); end
        do_req(1'b0, 2'b00, 1'b1, 32'h0000_0003, 32'h0, s, l, rd, er, adr, be, wd, got, rv2);
        tests++; if (rd !== 32'hFFFF_FFA5) begin fails++; $display("FAIL lb_rdata got %h exp ffffffa5", rd); end
        do_req(1'b0, 2'b00, 1'b0, 32'h0000_0003, 32'h0, s, l, rd, er, adr, be, wd, got, rv2);
        tests++; if (rd !== 32'h0000_00A5) begin fails++; $display("FAIL lbu_rdata got %h exp 000000a5", rd); end
    endtask

    task automatic test_half();
        int s, l; logic [31:0] rd, adr, wd; logic er, got, rv2; logic [3:0] be;
        do_req(1'b1, 2'b01, 1'b0, 32'hBFC0_0002, 32'h0000_8001, s, l, rd, er, adr, be, wd, got, rv2);
        tests++; if (be !== 4'b1100) begin fails++; $display("FAIL sh_be got %b exp 1100", be); end
        tests++; if (wd !== 32'h8001_8001) begin fails++; $display("FAIL sh_wdata got %h exp 80018001", wd); end
        tests++; if (adr !== 32'hBFC0_0000) begin fails++; $display("FAIL sh_addr got %h exp bfc00000", adr); end
        do_req(1'b0, 2'b01, 1'b1, 32'hBFC0_0002, 32'h0, s, l, rd, er, adr, be, wd, got, rv2);
        tests++; if (rd !== 32'hFFFF_8001) begin fails++; $display("FAIL lh_rdata got %h exp ffff8001", rd); end
        do_req(1'b0, 2'b01, 1'b0, 32'hBFC0_0002, 32'h0, s, l, rd, er, adr, be, wd, got, rv2);
        tests++; if (rd !== 32'h0000_8001) begin fails++; $display("FAIL lhu_rdata got %h exp 00008001", rd); end
    endtask

    task automatic test_misaligned();
        int s, l; logic [31:0] rd, adr, wd; logic er, got, rv2; logic [3:0] be;
        do_req(1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0, s, l, rd, er, adr, be, wd, got, rv2);
        tests++; if (s !== 0) begin fails++; $display("FAIL lw_mis_strobe got %0d exp 0", s); end
        tests++; if ({got, er, rd} !== {2'b11, 32'h0}) begin fails++; $display("FAIL lw_mis_rsp got %b%b/%h exp 11/0", got, er, rd); end
        tests++; if (l !== 1) begin fails++; $display("FAIL lw_mis_latency got %0d exp 1", l); end
        do_req(1'b0, 2'b01, 1'b1, 32'h0000_0001, 32'h0, s, l, rd, er, adr, be, wd, got, rv2);
        tests++; if (s !== 0 || {got, er, rd} !== {2'b11, 32'h0}) begin fails++; $display("FAIL lh_mis got s=%0d %b%b/%h exp s=0 11/0", s, got, er, rd); end
        do_req(1'b1, 2'b11, 1'b0, 32'h0000_0000, 32'h1234_5678, s, l, rd, er, adr, be, wd, got, rv2);
        tests++; if (s !== 0 || {got, er} !== 2'b11) begin fails++; $display("FAIL size11 got s=%0d %b%b exp s=0 11", s, got, er); end
    endtask

    task automatic test_timeout();
        int s, l; logic [31:0] rd, adr, wd; logic er, got, rv2; logic [3:0] be;
        stuck = 1'b1;
        do_req(1'b0, 2'b10, 1'b0, 32'h8000_0010, 32'h0, s, l, rd, er, adr, be, wd, got, rv2);
        tests++; if (s !== 8 || l !== 9) begin fails++; $display("FAIL tmo_cycles got %0d/%0d exp 8/9", s, l); end
        tests++; if ({got, er, rd} !== {2'b11, 32'h0}) begin fails++; $display("FAIL tmo_rsp got %b%b/%h exp 11/0", got, er, rd); end
        stuck = 1'b0;
        do_req(1'b0, 2'b10, 1'b0, 32'h8000_0010, 32'h0, s, l, rd, er, adr, be, wd, got, rv2);
        tests++; if ({er, rd} !== {1'b0, 32'hDEAD_BEEF}) begin fails++; $display("FAIL tmo_after got %b/%h exp 0/deadbeef", er, rd); end
    endtask

    task automatic test_reset_mid();
        int s, l; logic [31:0] rd, adr, wd; logic er, got, rv2; logic [3:0] be;
        logic rv_seen;
        stuck = 1'b1;
        rv_seen = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_addr = 32'h8000_0010;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        tests++; if (avm_read !== 1'b1) begin fails++; $display("FAIL mid_read_before got %b exp 1", avm_read); end
        #2 reset_n = 1'b0;
        #1;
        tests++; if ({avm_read, req_ready} !== 2'b00) begin fails++; $display("FAIL mid_async_drop got %b exp 00", {avm_read, req_ready}); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (resp_valid) rv_seen = 1'b1;
        end
        stuck = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        if (resp_valid) rv_seen = 1'b1;
        tests++; if (rv_seen !== 1'b0) begin fails++; $display("FAIL mid_no_resp got %b exp 0", rv_seen); end
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL mid_ready got %b exp 1", req_ready); end
        do_req(1'b0, 2'b10, 1'b0, 32'h8000_0010, 32'h0, s, l, rd, er, adr, be, wd, got, rv2);
        tests++; if ({got, er, rd} !== {2'b10, 32'hDEAD_BEEF}) begin fails++; $display("FAIL mid_lw got %b%b/%h exp 10/deadbeef", got, er, rd); end
        tests++; if (both_seen !== 1'b0) begin fails++; $display("FAIL rd_wr_overlap got %b exp 0", both_seen); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_misaligned();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
